// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 datapath blocks (initializer, shuffler,
// decryptor) and the S-RAM controller that arbitrates between them.
//
// Contents:
//   RAM_WIDTH_DEFAULT / MSG_LENGTH_DEFAULT - default data width and message size
//   MODE_INIT / MODE_SHUFFLE / MODE_DECRYPT - controller one-hot mode codes
//   state_t                                 - decryptor FSM state encoding
package rc4_pkg;

  localparam int RAM_WIDTH_DEFAULT  = 8;
  localparam int MSG_LENGTH_DEFAULT = 32;

  // One-hot so that each device owns exactly one bit of the mode vector.
  localparam logic [2:0] MODE_INIT    = 3'b001;
  localparam logic [2:0] MODE_SHUFFLE = 3'b010;
  localparam logic [2:0] MODE_DECRYPT = 3'b100;

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WAIT_SI,
    RD_SJ,
    WAIT_SJ,
    WR_SI,
    WR_SJ,
    RD_F,
    WAIT_F,
    WR_D,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_decryptor.sv
// RC4 keystream generator (PRGA) and decrypt stage. Runs after the S array
// has been initialised and shuffled; for every message byte it advances i/j,
// swaps S[i] and S[j], reads the keystream byte S[S[i]+S[j]] together with
// the ciphertext byte, and writes their XOR to the decrypted-message RAM.
//
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   start           - level request from the RAM controller, held for the run
//   finished        - high while in DONE
//   s_ram_out       - S RAM read data (synchronous, one cycle latency)
//   s_address       - S RAM address
//   s_ram_in        - S RAM write data
//   s_write_enable  - S RAM write strobe
//   rom_address     - encrypted-message ROM address
//   rom_out         - encrypted-message ROM data
//   d_address       - decrypted RAM address
//   d_ram_in        - decrypted RAM write data
//   d_write_enable  - decrypted RAM write strobe
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH      = RAM_WIDTH_DEFAULT,
  parameter int MSG_LENGTH     = MSG_LENGTH_DEFAULT,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      finished,
  input  logic [RAM_WIDTH-1:0]      s_ram_out,
  output logic [RAM_WIDTH-1:0]      s_address,
  output logic [RAM_WIDTH-1:0]      s_ram_in,
  output logic                      s_write_enable,
  output logic [MSG_ADDR_WIDTH-1:0] rom_address,
  input  logic [RAM_WIDTH-1:0]      rom_out,
  output logic [MSG_ADDR_WIDTH-1:0] d_address,
  output logic [RAM_WIDTH-1:0]      d_ram_in,
  output logic                      d_write_enable
);

  state_t state, next_state;

  logic [RAM_WIDTH-1:0]      i, j, si, sj, f, enc;
  logic [MSG_ADDR_WIDTH-1:0] k;
  logic                      last_byte;
  logic [RAM_WIDTH-1:0]      f_address;

  assign last_byte = (k == MSG_ADDR_WIDTH'(MSG_LENGTH - 1));
  // Keystream index wraps mod 2^RAM_WIDTH by truncation.
  assign f_address = si + sj;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Dropping start anywhere aborts back to IDLE, which also
  // covers the DONE -> IDLE handshake release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_SI;
      RD_SI:   next_state = WAIT_SI;
      WAIT_SI: next_state = RD_SJ;
      RD_SJ:   next_state = WAIT_SJ;
      WAIT_SJ: next_state = WR_SI;
      WR_SI:   next_state = WR_SJ;
      WR_SJ:   next_state = RD_F;
      RD_F:    next_state = WAIT_F;
      WAIT_F:  next_state = WR_D;
      WR_D:    next_state = last_byte ? DONE : RD_SI;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (!start) begin
      next_state = IDLE;
    end
  end

  // Working registers. Updates are gated by start so that an aborted run
  // leaves the registers exactly as they were when start dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i   <= '0;
      j   <= '0;
      si  <= '0;
      sj  <= '0;
      f   <= '0;
      enc <= '0;
      k   <= '0;
    end else if (start) begin
      case (state)
        IDLE: begin
          i <= RAM_WIDTH'(1);
          j <= '0;
          k <= '0;
        end
        WAIT_SI: begin
          si <= s_ram_out;
          j  <= j + s_ram_out;
        end
        WAIT_SJ: begin
          sj <= s_ram_out;
        end
        WAIT_F: begin
          f   <= s_ram_out;
          enc <= rom_out;
        end
        WR_D: begin
          if (!last_byte) begin
            k <= k + MSG_ADDR_WIDTH'(1);
            i <= i + RAM_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode. Read addresses are held across RD_x and WAIT_x so the
  // synchronous RAM sees a stable address for the whole two-cycle read.
  // When i == j the two swap writes hit the same location with the same
  // value, so no special case is needed.
  always_comb begin
    finished       = 1'b0;
    s_address      = '0;
    s_ram_in       = '0;
    s_write_enable = 1'b0;
    rom_address    = '0;
    d_address      = '0;
    d_ram_in       = '0;
    d_write_enable = 1'b0;
    case (state)
      RD_SI, WAIT_SI: s_address = i;
      RD_SJ, WAIT_SJ: s_address = j;
      WR_SI: begin
        s_address      = i;
        s_ram_in       = sj;
        s_write_enable = 1'b1;
      end
      WR_SJ: begin
        s_address      = j;
        s_ram_in       = si;
        s_write_enable = 1'b1;
      end
      RD_F, WAIT_F: begin
        s_address   = f_address;
        rom_address = k;
      end
      WR_D: begin
        d_address      = k;
        d_ram_in       = f ^ enc;
        d_write_enable = 1'b1;
      end
      DONE: finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_decryptor.sv
// Self-checking bench for rc4_decryptor. The bench owns the S RAM and the
// encrypted ROM; a reference RC4 PRGA computes the expected plaintext writes
// when each run is launched, and an independent monitor pops and compares
// them as the DUT writes the decrypted RAM.
module tb_rc4_decryptor;
  import rc4_pkg::*;

  localparam int MSG_LEN = 32;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       finished;
  logic [7:0] s_ram_out;
  logic [7:0] s_address;
  logic [7:0] s_ram_in;
  logic       s_write_enable;
  logic [4:0] rom_address;
  logic [7:0] rom_out;
  logic [4:0] d_address;
  logic [7:0] d_ram_in;
  logic       d_write_enable;

  logic [7:0] s_mem   [256];
  logic [7:0] s_image [256];
  logic [7:0] model_s [256];
  logic [7:0] rom_mem [MSG_LEN];
  logic [7:0] d_cap   [MSG_LEN];
  logic       load_s = 1'b0;

  exp_t exp_q[$];
  int   d_cycles[$];
  exp_t mon_e;
  int   cyc = 0;
  int   start_cyc = 0;
  int   overlap = 0;
  int   checks = 0;
  int   failures = 0;

  rc4_decryptor #(.RAM_WIDTH(8), .MSG_LENGTH(MSG_LEN), .MSG_ADDR_WIDTH(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .finished(finished),
    .s_ram_out(s_ram_out),
    .s_address(s_address),
    .s_ram_in(s_ram_in),
    .s_write_enable(s_write_enable),
    .rom_address(rom_address),
    .rom_out(rom_out),
    .d_address(d_address),
    .d_ram_in(d_ram_in),
    .d_write_enable(d_write_enable)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous S RAM and ROM models; load_s bulk-loads a fresh S image,
  // standing in for a rerun of the init/shuffle stages.
  always @(posedge clk) begin
    if (load_s) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_image[a];
    end else if (s_write_enable) begin
      s_mem[s_address] <= s_ram_in;
    end
    s_ram_out <= s_mem[s_address];
    rom_out   <= rom_mem[rom_address];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares every decrypted-RAM write against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_write_enable && d_write_enable) overlap <= overlap + 1;
      if (d_write_enable) begin
        d_cycles.push_back(cyc);
        d_cap[d_address] <= d_ram_in;
        if (exp_q.size() == 0) begin
          checkOutput("d_write_unexpected", {63'd0, d_write_enable}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("d_address", {59'd0, d_address}, {59'd0, mon_e.addr});
          checkOutput("d_data", {56'd0, d_ram_in}, {56'd0, mon_e.data});
        end
      end
    end
  end

  function automatic logic [63:0] allOutputs();
    return {27'd0, finished, s_write_enable, d_write_enable, s_address,
            s_ram_in, rom_address, d_address, d_ram_in};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic loadIdentity();
    for (int a = 0; a < 256; a++) s_image[a] = a[7:0];
  endtask

  // Key schedule for a 3-byte key, most significant byte first.
  task automatic loadKey(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] kj, t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    loadIdentity();
    kj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      kj = kj + s_image[a] + kb[a % 3];
      t = s_image[a];
      s_image[a] = s_image[kj];
      s_image[kj] = t;
    end
  endtask

  task automatic commitS();
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  // Reference PRGA over the loaded image; queues the first nbytes writes.
  task automatic buildExpected(input int nbytes);
    logic [7:0] ms [256];
    logic [7:0] mi, mj, t, fa;
    exp_t e;
    for (int a = 0; a < 256; a++) ms[a] = s_image[a];
    mi = 8'd0;
    mj = 8'd0;
    for (int n = 0; n < nbytes; n++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      fa = ms[mi] + ms[mj];
      e.addr = n[4:0];
      e.data = ms[fa] ^ rom_mem[n];
      exp_q.push_back(e);
    end
    for (int a = 0; a < 256; a++) model_s[a] = ms[a];
  endtask

  // Queues the expected writes and raises start; returns #1 after the edge
  // that samples start, i.e. in relative cycle 1.
  task automatic applyStimulus(input int nbytes);
    buildExpected(nbytes);
    d_cycles.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
  endtask

  task automatic waitFinished(output int rel);
    rel = -1;
    for (int n = 0; n < 400; n++) begin
      step();
      if (finished) begin
        rel = cyc - start_cyc + 1;
        return;
      end
    end
    checkOutput("finished_timeout", {63'd0, finished}, 64'd1);
  endtask

  task automatic waitWrites(input int n);
    for (int t = 0; t < 200; t++) begin
      if (d_cycles.size() >= n) return;
      step();
    end
    checkOutput("wait_writes_timeout", d_cycles.size(), n);
  endtask

  task automatic releaseStart();
    @(negedge clk);
    start = 1'b0;
    step();
    checkOutput("idle_after_start_drop", allOutputs(), 64'd0);
  endtask

  initial begin
    int rel, bad, strobes, fin_seen, guard;

    // Reset state.
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'h00;
    loadIdentity();
    #1;
    checkOutput("reset_outputs", allOutputs(), 64'd0);
    repeat (2) @(posedge clk);
    commitS();
    @(negedge clk);
    reset = 1'b0;
    step();
    checkOutput("idle_outputs", allOutputs(), 64'd0);

    // Identity S, zero ciphertext: first bytes equal the keystream.
    $display("[TB] identity S, zero ciphertext");
    applyStimulus(MSG_LEN);
    waitWrites(3);
    checkOutput("s2_after_byte2", {56'd0, s_mem[2]}, 64'd3);
    checkOutput("s3_after_byte2", {56'd0, s_mem[3]}, 64'd5);
    checkOutput("s5_after_byte2", {56'd0, s_mem[5]}, 64'd2);
    waitFinished(rel);
    checkOutput("d0_identity", {56'd0, d_cap[0]}, 64'h02);
    checkOutput("d1_identity", {56'd0, d_cap[1]}, 64'h05);
    checkOutput("d2_identity", {56'd0, d_cap[2]}, 64'h07);
    checkOutput("queue_empty_run1", exp_q.size(), 0);
    releaseStart();

    // Identity S, enc[0]=FF: value plus full-run timing.
    $display("[TB] identity S, timing run");
    rom_mem[0] = 8'hFF;
    loadIdentity();
    commitS();
    applyStimulus(MSG_LEN);
    waitFinished(rel);
    checkOutput("finished_latency", rel, 1 + 9 * MSG_LEN);
    checkOutput("d0_ff", {56'd0, d_cap[0]}, 64'hFD);
    checkOutput("d_write_count", d_cycles.size(), MSG_LEN);
    if (d_cycles.size() > 0)
      checkOutput("first_d_write_cycle", d_cycles[0] - start_cyc + 1, 9);
    bad = 0;
    for (int n = 1; n < d_cycles.size(); n++)
      if (d_cycles[n] - d_cycles[n-1] != 9) bad++;
    checkOutput("d_write_spacing", bad, 0);
    repeat (5) step();
    checkOutput("finished_held", {63'd0, finished}, 64'd1);
    releaseStart();
    checkOutput("queue_empty_run2", exp_q.size(), 0);

    // Abort during the S[i] write of byte 5.
    $display("[TB] abort during byte 5");
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    loadIdentity();
    commitS();
    applyStimulus(5);
    guard = 0;
    while (!(s_write_enable && d_cycles.size() == 5) && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("abort_reached_wr_si", {63'd0, s_write_enable}, 64'd1);
    start = 1'b0;
    step();
    checkOutput("abort_outputs", allOutputs(), 64'd0);
    strobes = 0;
    fin_seen = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (s_write_enable || d_write_enable) strobes++;
      if (finished) fin_seen++;
    end
    checkOutput("abort_no_writes", strobes, 0);
    checkOutput("abort_no_finished", fin_seen, 0);
    checkOutput("abort_d_count", d_cycles.size(), 5);
    checkOutput("queue_empty_abort", exp_q.size(), 0);

    // Asynchronous reset in the WAIT_F cycle of byte 2.
    $display("[TB] reset during WAIT_F");
    loadIdentity();
    commitS();
    applyStimulus(2);
    guard = 0;
    while ((cyc - start_cyc + 1) != 9 * 2 + 8 && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("reached_wait_f_rom", {59'd0, rom_address}, 64'd2);
    reset = 1'b1;
    start = 1'b0;
    #1;
    checkOutput("reset_midrun_outputs", allOutputs(), 64'd0);
    checkOutput("reset_d_count", d_cycles.size(), 2);
    checkOutput("queue_empty_reset", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    loadIdentity();
    commitS();
    applyStimulus(MSG_LEN);
    checkOutput("restart_i_is_1", {56'd0, s_address}, 64'd1);
    waitFinished(rel);
    checkOutput("restart_latency", rel, 1 + 9 * MSG_LEN);
    checkOutput("queue_empty_restart", exp_q.size(), 0);
    releaseStart();

    // Shuffled S from a real key and random ciphertext.
    $display("[TB] keyed S, random ciphertext");
    for (int a = 0; a < MSG_LEN; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    loadKey(24'h000249);
    commitS();
    applyStimulus(MSG_LEN);
    waitFinished(rel);
    checkOutput("queue_empty_keyed", exp_q.size(), 0);
    checkOutput("keyed_d_count", d_cycles.size(), MSG_LEN);
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== model_s[a]) bad++;
    checkOutput("keyed_final_s", bad, 0);
    releaseStart();

    checkOutput("write_enables_exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
